hazard_scoreboard_unit: RTL and testbench
=========================================

Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the single-load-slot hazard detector in the pipelined 16-bit CPU.
- Sits beside the ID stage.
- Tracks pending load results per architectural register with countdown counters, so memory latency is configurable instead of fixed at one EX-stage load.
- Resolves ID-stage control transfers against the fetch prediction, drives redirect/flush, and keeps saturating stall/flush statistics counters.

Parameters:
- WORD_SIZE, 16, datapath/PC width.
- NUM_REGS, 4, architectural registers tracked.
- RADDR_W, 2, register address width (log2 NUM_REGS).
- LOAD_LAT, 1, cycles after issue before a load result is forwardable to ID (legal 1..7).
- CNT_W, 3, per-register counter width (must hold LOAD_LAT).
- STAT_W, 16, statistics counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction (not a bubble).
- id_rs  in  RADDR_W  source register 1.
- id_use_rs  in  1  instruction reads rs.
- id_rt  in  RADDR_W  source register 2.
- id_use_rt  in  1  instruction reads rt.
- id_rd  in  RADDR_W  destination register.
- id_writes_rd  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_is_jump  in  1  control transfer resolved in ID (branch/JMP/JAL/JPR/JRL).
- id_jump_target  in  WORD_SIZE  resolved next PC of the ID instruction.
- id_pred_next_pc  in  WORD_SIZE  next PC fetch predicted for this instruction.
- mem_wait  in  1  memory busy; whole front end frozen.
- stall  out  1  hold PC and IF/ID, insert bubble into EX.
- issue  out  1  ID instruction advances to EX this cycle.
- redirect  out  1  fetch must load redirect_pc next edge.
- redirect_pc  out  WORD_SIZE  corrected fetch address.
- flush_if  out  1  squash instruction currently in IF.
- stall_count  out  STAT_W  cycles with stall=1 caused by data hazard.
- flush_count  out  STAT_W  redirects taken.

Behaviour:
- State: cnt[r], CNT_W bits, for each register r; stall_count; flush_count.
- Reset (reset_n low, asynchronous): all cnt = 0, both statistics counters = 0. Combinational outputs then evaluate to stall=0, issue=0 (for id_valid=0), redirect=0, flush_if=0, redirect_pc=0.
- data_hz = id_valid & ((id_use_rs & cnt[id_rs]!=0) | (id_use_rt & cnt[id_rt]!=0)). Combinational from current state.
- stall = mem_wait | data_hz.
- issue = id_valid & !stall.
- redirect = issue & id_is_jump & (id_jump_target != id_pred_next_pc).
- flush_if = redirect.
- redirect_pc = id_jump_target when redirect, else 0.
- A stalled jump never redirects. Data hazard has priority over control hazard; the redirect fires on the cycle the jump finally issues.
- Counter update per posedge, for each r:
  - If mem_wait: hold all counters.
  - Else if issue & id_writes_rd & r==id_rd: cnt[r] = id_is_load ? LOAD_LAT : 0. A newer ALU write supersedes the pending load; it is forwarded normally.
  - Else if cnt[r]!=0: cnt[r] = cnt[r]-1.
- Set beats decrement in the same cycle for the same register.
- Dependent instruction behaviour: LOAD_LAT=N gives exactly N stall cycles when the instruction immediately after a load reads its rd. A consumer k instructions later (no intervening stalls) stalls max(0, N-k+1) cycles.
- Statistics:
  - stall_count increments when data_hz & !mem_wait.
  - flush_count increments when redirect.
  - Both saturate at all-ones; no wrap.
- id_valid=0: no stall from data hazard, no issue, counters still decrement.
- Register read where the source equals a pending load rd but use bit is 0: no stall.

Test Plan:
- LOAD_LAT=1; load r2 issues, next cycle ADD reads r2 as rs -> stall=1 for exactly 1 cycle, then issue=1; stall_count=1.
- LOAD_LAT=3; load r1, then independent instr, then reader of r1 as rt -> reader stalls 2 cycles; stall_count=2.
- Load r3 followed immediately by ALU write to r3, then reader of r3 -> no stall (cnt[3] cleared to 0).
- Jump in ID with id_jump_target=16'h0040, id_pred_next_pc=16'h0011, no hazard -> redirect=1, flush_if=1, redirect_pc=16'h0040 for one cycle; flush_count=1. With target equal to prediction -> redirect=0.
- Jump reading a pending load register with LOAD_LAT=1 and mispredicted target -> cycle 1: stall=1, redirect=0; cycle 2: issue=1, redirect=1.
- mem_wait=1 for 4 cycles with cnt[0]=2 -> stall=1, counters hold at 2, stall_count unchanged. reset_n pulsed low mid-operation -> all cnt and statistics 0 immediately, no clock edge needed.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: per-register load countdown scoreboard beside ID,
// ID-stage control-transfer resolution and saturating stall/flush statistics.
module hazard_scoreboard_unit #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS  = 4,
  parameter int RADDR_W   = 2,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 3,
  parameter int STAT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 id_valid,
  input  logic [RADDR_W-1:0]   id_rs,
  input  logic                 id_use_rs,
  input  logic [RADDR_W-1:0]   id_rt,
  input  logic                 id_use_rt,
  input  logic [RADDR_W-1:0]   id_rd,
  input  logic                 id_writes_rd,
  input  logic                 id_is_load,
  input  logic                 id_is_jump,
  input  logic [WORD_SIZE-1:0] id_jump_target,
  input  logic [WORD_SIZE-1:0] id_pred_next_pc,
  input  logic                 mem_wait,
  output logic                 stall,
  output logic                 issue,
  output logic                 redirect,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 flush_if,
  output logic [STAT_W-1:0]    stall_count,
  output logic [STAT_W-1:0]    flush_count
);

  logic [CNT_W-1:0]  r_cnt [NUM_REGS];
  logic [STAT_W-1:0] r_stall_cnt;
  logic [STAT_W-1:0] r_flush_cnt;

  logic w_rs_busy;
  logic w_rt_busy;
  logic w_data_hz;
  logic w_stall;
  logic w_issue;
  logic w_redirect;

  assign w_rs_busy  = id_use_rs && (r_cnt[id_rs] != '0);
  assign w_rt_busy  = id_use_rt && (r_cnt[id_rt] != '0);
  assign w_data_hz  = id_valid && (w_rs_busy || w_rt_busy);
  assign w_stall    = mem_wait || w_data_hz;
  assign w_issue    = id_valid && !w_stall;
  // A stalled jump cannot redirect; it resolves when it finally issues.
  assign w_redirect = w_issue && id_is_jump &&
                      (id_jump_target != id_pred_next_pc);

  assign stall       = w_stall;
  assign issue       = w_issue;
  assign redirect    = w_redirect;
  assign flush_if    = w_redirect;
  assign redirect_pc = w_redirect ? id_jump_target : '0;
  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!mem_wait) begin
        // A newer write to rd supersedes any pending load countdown.
        for (int r = 0; r < NUM_REGS; r++) begin
          if (w_issue && id_writes_rd && (id_rd == RADDR_W'(r))) begin
            r_cnt[r] <= id_is_load ? CNT_W'(LOAD_LAT) : '0;
          end else if (r_cnt[r] != '0) begin
            r_cnt[r] <= r_cnt[r] - CNT_W'(1);
          end
        end
      end
      if (w_data_hz && !mem_wait && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STAT_W'(1);
      end
      if (w_redirect && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: two instances (LOAD_LAT 1 and 3),
// directed vectors, expected values queued and checked by a monitor.
module tb_hazard_scoreboard_unit;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [1:0]  id_rs;
  logic        id_use_rs;
  logic [1:0]  id_rt;
  logic        id_use_rt;
  logic [1:0]  id_rd;
  logic        id_writes_rd;
  logic        id_is_load;
  logic        id_is_jump;
  logic [15:0] id_jump_target;
  logic [15:0] id_pred_next_pc;
  logic        mem_wait;

  logic        st1, is1, rd1, fl1;
  logic [15:0] pc1;
  logic [2:0]  sc1, fc1;
  logic        st3, is3, rd3, fl3;
  logic [15:0] pc3;
  logic [15:0] sc3, fc3;

  hazard_scoreboard_unit #(.LOAD_LAT(1), .STAT_W(3)) u1 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_use_rs(id_use_rs),
    .id_rt(id_rt), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_writes_rd(id_writes_rd),
    .id_is_load(id_is_load), .id_is_jump(id_is_jump),
    .id_jump_target(id_jump_target),
    .id_pred_next_pc(id_pred_next_pc),
    .mem_wait(mem_wait),
    .stall(st1), .issue(is1), .redirect(rd1),
    .redirect_pc(pc1), .flush_if(fl1),
    .stall_count(sc1), .flush_count(fc1)
  );

  hazard_scoreboard_unit #(.LOAD_LAT(3), .STAT_W(16)) u3 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_use_rs(id_use_rs),
    .id_rt(id_rt), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_writes_rd(id_writes_rd),
    .id_is_load(id_is_load), .id_is_jump(id_is_jump),
    .id_jump_target(id_jump_target),
    .id_pred_next_pc(id_pred_next_pc),
    .mem_wait(mem_wait),
    .stall(st3), .issue(is3), .redirect(rd3),
    .redirect_pc(pc3), .flush_if(fl3),
    .stall_count(sc3), .flush_count(fc3)
  );

  typedef struct {
    int          sel;
    logic        st;
    logic        is;
    logic        rd;
    logic [15:0] pc;
    int          sc;
    int          fc;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin : mon
    exp_t        e;
    logic        a_st, a_is, a_rd, a_fl;
    logic [15:0] a_pc;
    int          a_sc, a_fc;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel == 1) begin
        a_st = st1; a_is = is1; a_rd = rd1; a_fl = fl1;
        a_pc = pc1; a_sc = int'(sc1); a_fc = int'(fc1);
      end else begin
        a_st = st3; a_is = is3; a_rd = rd3; a_fl = fl3;
        a_pc = pc3; a_sc = int'(sc3); a_fc = int'(fc3);
      end
      n_cmp++;
      if (a_st !== e.st || a_is !== e.is || a_rd !== e.rd ||
          a_fl !== e.rd || a_pc !== e.pc ||
          a_sc != e.sc || a_fc != e.fc) begin
        n_bad++;
        $display("FAIL %s: got st=%0b is=%0b rd=%0b fl=%0b pc=%h sc=%0d fc=%0d; expected st=%0b is=%0b rd=%0b fl=%0b pc=%h sc=%0d fc=%0d",
                 e.nm, a_st, a_is, a_rd, a_fl, a_pc, a_sc, a_fc,
                 e.st, e.is, e.rd, e.rd, e.pc, e.sc, e.fc);
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic v,
                     input logic [1:0] rs, input logic urs,
                     input logic [1:0] rt, input logic urt,
                     input logic [1:0] rd, input logic wrd,
                     input logic ld, input logic jmp,
                     input logic [15:0] tgt, input logic [15:0] pred,
                     input logic mw);
    id_valid        = v;
    id_rs           = rs;
    id_use_rs       = urs;
    id_rt           = rt;
    id_use_rt       = urt;
    id_rd           = rd;
    id_writes_rd    = wrd;
    id_is_load      = ld;
    id_is_jump      = jmp;
    id_jump_target  = tgt;
    id_pred_next_pc = pred;
    mem_wait        = mw;
  endtask

  task automatic nop();
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  task automatic ldr(input logic [1:0] rd);
    ins(1, 0, 0, 0, 0, rd, 1, 1, 0, 16'h0, 16'h0, 0);
  endtask

  task automatic chk(input int sel, input logic st, input logic is,
                     input logic rd, input logic [15:0] pc,
                     input int sc, input int fc, input string nm);
    exp_t e;
    e.sel = sel; e.st = st; e.is = is; e.rd = rd;
    e.pc = pc; e.sc = sc; e.fc = fc; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic rstp();
    go();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    nop();
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    nop();

    go(); chk(1, 0, 0, 0, 16'h0, 0, 0, "rst_u1");
    go(); chk(3, 0, 0, 0, 16'h0, 0, 0, "rst_u3");
    go(); reset_n = 1'b1;

    // load-use with LOAD_LAT=1
    go(); ldr(2); chk(1, 0, 1, 0, 16'h0, 0, 0, "t1_ld");
    go(); ins(1, 2, 1, 0, 1, 1, 1, 0, 0, 16'h0, 16'h0, 0);
    chk(1, 1, 0, 0, 16'h0, 0, 0, "t1_stall");
    go(); chk(1, 0, 1, 0, 16'h0, 1, 0, "t1_issue");
    go(); nop(); chk(1, 0, 0, 0, 16'h0, 1, 0, "t1_cnt");

    // LOAD_LAT=3, consumer two instructions later
    rstp();
    go(); ldr(1); chk(3, 0, 1, 0, 16'h0, 0, 0, "t2_ld");
    go(); ins(1, 0, 1, 0, 1, 2, 1, 0, 0, 16'h0, 16'h0, 0);
    chk(3, 0, 1, 0, 16'h0, 0, 0, "t2_indep");
    go(); ins(1, 0, 0, 1, 1, 3, 1, 0, 0, 16'h0, 16'h0, 0);
    chk(3, 1, 0, 0, 16'h0, 0, 0, "t2_st1");
    go(); chk(3, 1, 0, 0, 16'h0, 1, 0, "t2_st2");
    go(); chk(3, 0, 1, 0, 16'h0, 2, 0, "t2_iss");
    go(); nop(); chk(3, 0, 0, 0, 16'h0, 2, 0, "t2_cnt");

    // ALU write supersedes load; use bits; bubbles still count down
    rstp();
    go(); ldr(3); chk(3, 0, 1, 0, 16'h0, 0, 0, "t3_ld");
    go(); ins(1, 0, 1, 0, 1, 3, 1, 0, 0, 16'h0, 16'h0, 0);
    chk(3, 0, 1, 0, 16'h0, 0, 0, "t3_alu");
    go(); ins(1, 3, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
    chk(3, 0, 1, 0, 16'h0, 0, 0, "t3_nostall");
    go(); ldr(2); chk(3, 0, 1, 0, 16'h0, 0, 0, "t3_ld2");
    go(); ins(1, 2, 0, 2, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
    chk(3, 0, 1, 0, 16'h0, 0, 0, "t3_usebit");
    go(); ldr(1); chk(3, 0, 1, 0, 16'h0, 0, 0, "t3_ld1");
    go(); ins(0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
    chk(3, 0, 0, 0, 16'h0, 0, 0, "t3_bub1");
    go(); chk(3, 0, 0, 0, 16'h0, 0, 0, "t3_bub2");
    go(); ins(1, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
    chk(3, 1, 0, 0, 16'h0, 0, 0, "t3_stall");
    go(); chk(3, 0, 1, 0, 16'h0, 1, 0, "t3_iss");

    // jump mispredict and correct prediction
    rstp();
    go(); ins(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0040, 16'h0011, 0);
    chk(1, 0, 1, 1, 16'h0040, 0, 0, "t4_redir");
    go(); ins(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0022, 16'h0022, 0);
    chk(1, 0, 1, 0, 16'h0, 0, 1, "t4_match");
    go(); nop(); chk(1, 0, 0, 0, 16'h0, 0, 1, "t4_cnt");

    // jump waits on a pending load, then redirects
    go(); ldr(0); chk(1, 0, 1, 0, 16'h0, 0, 1, "t5_ld");
    go(); ins(1, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0080, 16'h0012, 0);
    chk(1, 1, 0, 0, 16'h0, 0, 1, "t5_stall");
    go(); chk(1, 0, 1, 1, 16'h0080, 1, 1, "t5_redir");
    go(); nop(); chk(1, 0, 0, 0, 16'h0, 1, 2, "t5_cnt");

    // mem_wait freezes counters and statistics
    rstp();
    go(); ldr(0); chk(3, 0, 1, 0, 16'h0, 0, 0, "t6_ld");
    go(); nop(); chk(3, 0, 0, 0, 16'h0, 0, 0, "t6_bub");
    for (int i = 0; i < 4; i++) begin
      go(); ins(1, 0, 1, 0, 0, 1, 1, 0, 0, 16'h0, 16'h0, 1);
      chk(3, 1, 0, 0, 16'h0, 0, 0, "t6_mw");
    end
    go(); ins(1, 0, 1, 0, 0, 1, 1, 0, 0, 16'h0, 16'h0, 0);
    chk(3, 1, 0, 0, 16'h0, 0, 0, "t6_st1");
    go(); chk(3, 1, 0, 0, 16'h0, 1, 0, "t6_st2");
    go(); chk(3, 0, 1, 0, 16'h0, 2, 0, "t6_iss");
    go(); ldr(1); chk(3, 0, 1, 0, 16'h0, 2, 0, "t6_ld1");
    go(); ins(1, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
    chk(3, 1, 0, 0, 16'h0, 2, 0, "t6_st3");
    go(); reset_n = 1'b0;
    chk(3, 0, 1, 0, 16'h0, 0, 0, "t6_async");
    go(); reset_n = 1'b1; nop();

    // flush_count saturates at all-ones (3-bit instance)
    for (int i = 0; i < 9; i++) begin
      go(); ins(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0100, 16'h0000, 0);
      chk(1, 0, 1, 1, 16'h0100, 0, (i < 7) ? i : 7, "t7_sat");
    end
    go(); nop();

    for (int i = 0; i < 10 && q.size() > 0; i++) go();
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
